// File: rtl/regfile_read_port_if.sv
// -----------------------------------------------------------------------------
// regfile_read_port_if
// Bundles the request/response handshake of the register-file read port with
// the signals that run between the port and the register array.
//
//   rd_req    requester -> port   read request, qualified by rd_ready
//   rd_id     requester -> port   register index, sampled on acceptance
//   rd_ready  port -> requester   port can accept a request this cycle
//   rden      port -> array       one-hot row read enables
//   bitline   array -> port       shared read bitline
//   wr_en     array -> port       array write strobe in the same cycle
//   wr_id     array -> port       register index being written
//   wr_data   array -> port       data being written
//   rd_valid  port -> requester   one-cycle pulse, rd_data is new
//   rd_data   port -> requester   captured read result, held until next capture
//   rd_bypass port -> requester   result came from write forwarding
//
// modport slave  : the read port itself.
// modport master : its environment (requester plus register array).
// -----------------------------------------------------------------------------
interface regfile_read_port_if;
  logic        rd_req;
  logic [3:0]  rd_id;
  logic        rd_ready;
  logic [15:0] rden;
  logic [15:0] bitline;
  logic        wr_en;
  logic [3:0]  wr_id;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_bypass;

  modport master (
    output rd_req, rd_id, bitline, wr_en, wr_id, wr_data,
    input  rd_ready, rden, rd_valid, rd_data, rd_bypass
  );

  modport slave (
    input  rd_req, rd_id, bitline, wr_en, wr_id, wr_data,
    output rd_ready, rden, rd_valid, rd_data, rd_bypass
  );
endinterface

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// Single read port in front of a 16 x 16-bit register array that drives a
// shared bitline. A read walks IDLE -> DRIVE -> DONE: the index is latched on
// acceptance, the matching row enable is driven for one cycle, and the bitline
// (or a same-cycle write to that register) is captured into rd_data.
// Latency is fixed: accept in N, rden in N+1, rd_valid/rd_data in N+2. A new
// request may be accepted in DONE, giving one read every two cycles.
//
//   clk  rising-edge clock
//   rst  synchronous, active-low reset
//   bus  regfile_read_port_if.slave (see the interface for signal roles)
//
// Parameter ZERO_R0: when 1, register 0 reads as 16'h0000 and row 0 is never
// enabled.
// -----------------------------------------------------------------------------
module regfile_read_port #(
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_read_port_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  id_q;
  logic [15:0] data_q;
  logic        bypass_q;

  logic        ready;
  logic        accept;
  logic        r0_read;
  logic        fwd_hit;
  logic [15:0] rden_c;
  logic [15:0] capture_data;
  logic        capture_bypass;

  // Ready depends only on the state register, so acceptance never loops back
  // through the next-state logic.
  assign ready   = (state_q != DRIVE);
  assign accept  = bus.rd_req && ready;
  assign r0_read = ZERO_R0 && (id_q == 4'd0);

  // A write to the register being read lands in the array at the same edge the
  // bitline is captured, so the bitline still shows the old value: forward it.
  // A write in the acceptance cycle is already in the array by DRIVE, which is
  // why only the DRIVE-cycle write is compared here.
  assign fwd_hit = bus.wr_en && (bus.wr_id == id_q);

  always_comb begin
    if (r0_read) begin
      capture_data   = 16'h0000;
      capture_bypass = 1'b0;
    end else if (fwd_hit) begin
      capture_data   = bus.wr_data;
      capture_bypass = 1'b1;
    end else begin
      capture_data   = bus.bitline;
      capture_bypass = 1'b0;
    end
  end

  // NOTE: every signal written in always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    rden_c  = 16'h0000;
    case (state_q)
      IDLE: begin
        if (accept) state_d = DRIVE;
      end
      DRIVE: begin
        if (!r0_read) rden_c = 16'(1) << id_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = accept ? DRIVE : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      id_q     <= 4'd0;
      data_q   <= 16'h0000;
      bypass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) id_q <= bus.rd_id;
      if (state_q == DRIVE) begin
        data_q   <= capture_data;
        bypass_q <= capture_bypass;
      end
    end
  end

  assign bus.rd_ready  = ready;
  assign bus.rden      = rden_c;
  assign bus.rd_valid  = (state_q == DONE);
  assign bus.rd_data   = data_q;
  // bypass_q is only refreshed on entry to DONE; mask it everywhere else.
  assign bus.rd_bypass = bypass_q && (state_q == DONE);

endmodule

// File: tb/tb_regfile_read_port.sv
// -----------------------------------------------------------------------------
// tb_regfile_read_port
// Runs two instances in lockstep (ZERO_R0=1 and ZERO_R0=0) from the same
// stimulus, each with its own bitline driven by a shared register-array model.
// Expected results are pushed when a read is driven and popped when rd_valid
// appears.
// -----------------------------------------------------------------------------
module tb_regfile_read_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [3:0]  rd_id;
  logic        wr_en;
  logic [3:0]  wr_id;
  logic [15:0] wr_data;
  logic        bl_force;
  logic [15:0] bl_z;
  logic [15:0] bl_n;
  logic [15:0] regs [16];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] dz;
    logic        bz;
    logic [15:0] dn;
    logic        bn;
  } exp_t;
  exp_t exp_q[$];

  regfile_read_port_if bus_z ();
  regfile_read_port_if bus_n ();

  regfile_read_port #(.ZERO_R0(1'b1)) dut_z (.clk(clk), .rst(rst), .bus(bus_z));
  regfile_read_port #(.ZERO_R0(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  always #5 clk = ~clk;

  assign bus_z.rd_req  = rd_req;
  assign bus_z.rd_id   = rd_id;
  assign bus_z.wr_en   = wr_en;
  assign bus_z.wr_id   = wr_id;
  assign bus_z.wr_data = wr_data;
  assign bus_z.bitline = bl_z;
  assign bus_n.rd_req  = rd_req;
  assign bus_n.rd_id   = rd_id;
  assign bus_n.wr_en   = wr_en;
  assign bus_n.wr_id   = wr_id;
  assign bus_n.wr_data = wr_data;
  assign bus_n.bitline = bl_n;

  // Register array model: written at the edge, read through the row enables.
  always @(posedge clk) if (wr_en) regs[wr_id] <= wr_data;

  always_comb begin
    bl_z = 16'h0000;
    bl_n = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (bus_z.rden[i]) bl_z = bl_z | regs[i];
      if (bus_n.rden[i]) bl_n = bl_n | regs[i];
    end
    if (bl_force) begin
      bl_z = 16'hFFFF;
      bl_n = 16'hFFFF;
    end
  end

  // Per-unit views of the outputs so the monitor can loop over both.
  logic [15:0] rden_u  [2];
  logic [15:0] data_u  [2];
  logic        ready_u [2];
  logic        valid_u [2];
  logic        byp_u   [2];
  assign rden_u[0]  = bus_z.rden;      assign rden_u[1]  = bus_n.rden;
  assign data_u[0]  = bus_z.rd_data;   assign data_u[1]  = bus_n.rd_data;
  assign ready_u[0] = bus_z.rd_ready;  assign ready_u[1] = bus_n.rd_ready;
  assign valid_u[0] = bus_z.rd_valid;  assign valid_u[1] = bus_n.rd_valid;
  assign byp_u[0]   = bus_z.rd_bypass; assign byp_u[1]   = bus_n.rd_bypass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  logic        mon_en = 1'b0;
  logic        rst_at_edge = 1'b0;
  logic [15:0] prev_data [2];

  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int u = 0; u < 2; u++) begin
        check($sformatf("rden_onehot%0d", u), 32'($countones(rden_u[u]) <= 1), 1);
        if (ready_u[u]) check($sformatf("rden_idle%0d", u), rden_u[u], 0);
        if (!valid_u[u]) begin
          check($sformatf("byp_quiet%0d", u), byp_u[u], 0);
          if (rst_at_edge) check($sformatf("data_hold%0d", u), data_u[u], prev_data[u]);
        end
      end
      check("valid_lockstep", valid_u[1], valid_u[0]);
      if (valid_u[0]) begin
        if (exp_q.size() == 0) begin
          check("unexp_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data_z", data_u[0], e.dz);
          check("byp_z",  byp_u[0],  e.bz);
          check("data_n", data_u[1], e.dn);
          check("byp_n",  byp_u[1],  e.bn);
        end
      end
    end
    prev_data[0] = data_u[0];
    prev_data[1] = data_u[1];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] id, input logic [15:0] val);
    wr_en   = 1'b1;
    wr_id   = id;
    wr_data = val;
    step();
    wr_en   = 1'b0;
  endtask

  // One read. Called right after an edge with the port able to accept. dwe/dwid/
  // dwdata is the array write during DRIVE; keep_req holds rd_req high (with a
  // junk index) through DRIVE, which the port must ignore.
  task automatic do_read(input logic [3:0] id, input logic dwe, input logic [3:0] dwid,
                         input logic [15:0] dwdata, input logic keep_req);
    exp_t        e;
    logic [15:0] bl;
    int          waited = 0;
    while (!bus_z.rd_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!bus_z.rd_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    rd_req = 1'b1;
    rd_id  = id;
    step();
    // DRIVE
    rd_req  = keep_req;
    rd_id   = ~id;
    wr_en   = dwe;
    wr_id   = dwid;
    wr_data = dwdata;
    bl   = bl_force ? 16'hFFFF : regs[id];
    e.dn = (dwe && dwid == id) ? dwdata : bl;
    e.bn = dwe && (dwid == id);
    e.dz = (id == 4'd0) ? 16'h0000 : e.dn;
    e.bz = (id == 4'd0) ? 1'b0 : e.bn;
    exp_q.push_back(e);
    check("rden_z", bus_z.rden, (id == 4'd0) ? 16'h0000 : (16'h0001 << id));
    check("rden_n", bus_n.rden, 16'h0001 << id);
    check("ready_drive", bus_z.rd_ready, 0);
    check("valid_drive", bus_z.rd_valid, 0);
    step();
    // DONE
    wr_en = 1'b0;
    check("valid_done", bus_z.rd_valid, 1);
    check("ready_done", bus_z.rd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    rd_req   = 1'b0;
    rd_id    = 4'd0;
    wr_en    = 1'b0;
    wr_id    = 4'd0;
    wr_data  = 16'h0000;
    bl_force = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_ready", bus_z.rd_ready, 1);
    check("rst_rden",  bus_z.rden, 0);
    check("rst_valid", bus_z.rd_valid, 0);
    check("rst_data",  bus_z.rd_data, 0);
    check("rst_byp",   bus_z.rd_bypass, 0);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Preload the array
    for (int i = 0; i < 16; i++) write_reg(4'(i), 16'($urandom));
    write_reg(4'd5, 16'hBEEF);
    write_reg(4'd3, 16'h1111);

    // Basic read
    do_read(4'd5, 1'b0, 4'd0, 16'h0000, 1'b0);
    step();

    // Forwarding hit, then a write to a different register
    do_read(4'd3, 1'b1, 4'd3, 16'h2222, 1'b0);
    write_reg(4'd3, 16'h1111);
    do_read(4'd3, 1'b1, 4'd4, 16'h2222, 1'b0);
    step();

    // Write in the acceptance cycle: seen on the bitline, not forwarded
    wr_en   = 1'b1;
    wr_id   = 4'd3;
    wr_data = 16'h3333;
    do_read(4'd3, 1'b0, 4'd0, 16'h0000, 1'b0);
    step();

    // Register 0 with the bitline forced high, then a write to R0 during DRIVE
    bl_force = 1'b1;
    do_read(4'd0, 1'b0, 4'd0, 16'h0000, 1'b0);
    bl_force = 1'b0;
    do_read(4'd0, 1'b1, 4'd0, 16'hABCD, 1'b0);
    step();

    // Back-to-back with rd_req held high
    do_read(4'd1, 1'b0, 4'd0, 16'h0000, 1'b1);
    do_read(4'd2, 1'b0, 4'd0, 16'h0000, 1'b1);
    do_read(4'd3, 1'b0, 4'd0, 16'h0000, 1'b0);
    step();
    check("b2b_idle_ready", bus_z.rd_ready, 1);
    check("b2b_idle_valid", bus_z.rd_valid, 0);

    // Every index, fresh contents, streamed back-to-back
    for (int i = 0; i < 16; i++) write_reg(4'(i), 16'($urandom));
    for (int i = 0; i < 16; i++) do_read(4'(i), 1'b0, 4'd0, 16'h0000, i != 15);
    step();

    // Reset in the middle of a read
    rd_req = 1'b1;
    rd_id  = 4'd7;
    step();
    rd_req = 1'b0;
    check("midrst_drive_rden", bus_z.rden, 16'h0080);
    rst = 1'b0;
    step();
    check("midrst_rden",  bus_z.rden, 0);
    check("midrst_valid", bus_z.rd_valid, 0);
    check("midrst_data",  bus_z.rd_data, 0);
    check("midrst_data_n", bus_n.rd_data, 0);
    check("midrst_ready", bus_z.rd_ready, 1);
    rst = 1'b1;
    repeat (5) step();

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
